// File: rtl/fpu_sched_pkg.sv
// Shared types for the fpu_scheduler slice: FSM state encoding and the default
// operand width of the shared floating unit.
package fpu_sched_pkg;

  localparam int FP_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping around; returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int ID_W = $clog2(NUM_REQ);

  always_comb begin
    int              sum;
    logic [ID_W-1:0] idx;
    logic            found;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fpu_scheduler.sv
// Round-robin scheduler sharing one floating unit between NUM_REQ requesters:
// grant in IDLE, hold operands for FPU_LATENCY cycles, return result in RESP.
module fpu_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = FP_WIDTH,
  parameter int FPU_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_op,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]           resp_value,
  output logic [WIDTH-1:0]           fpu_a,
  output logic [WIDTH-1:0]           fpu_b,
  output logic                       fpu_op,
  input  logic [WIDTH-1:0]           fpu_value,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FPU_LATENCY + 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               op_op_q, op_op_d;
  logic [WIDTH-1:0]   resp_value_q, resp_value_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are offered only in IDLE and are masked while reset is held.
  assign req_ready  = (state_q == IDLE && !rst) ? grant : '0;
  assign resp_valid = resp_valid_q;
  assign resp_value = resp_value_q;
  assign fpu_a      = op_a_q;
  assign fpu_b      = op_b_q;
  assign fpu_op     = op_op_q;
  assign busy       = busy_q;
  assign cur_id     = cur_id_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_id_d     = cur_id_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_op_d      = op_op_q;
    resp_value_d = resp_value_q;
    resp_valid_d = '0;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          op_a_d   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
          op_b_d   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
          op_op_d  = req_op[grant_idx];
          cur_id_d = grant_idx;
          // Explicit wrap so non-power-of-two NUM_REQ never reaches an unused index.
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d    = CNT_W'(FPU_LATENCY);
          busy_d   = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          resp_value_d           = fpu_value;
          resp_valid_d[cur_id_q] = 1'b1;
          state_d                = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: next-state values are computed with blocking assignments in
  // always_comb; the flops below use <= only, so all _q update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_op_q      <= 1'b0;
      resp_value_q <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_id_q     <= cur_id_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_op_q      <= op_op_d;
      resp_value_q <= resp_value_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler: two instances (FPU_LATENCY 2 and 1) with XOR
// stub units; expected responses are queued at grant time and popped on resp_valid.
module tb_fpu_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    int          id;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  logic [31:0] opa0[N], opb0[N], opa1[N], opb1[N];

  logic [N-1:0]   req_valid0, req_op0, req_ready0, resp_valid0;
  logic [N*W-1:0] req_a0, req_b0;
  logic [W-1:0]   resp_value0, fpu_a0, fpu_b0, fpu_value0, stub0_q;
  logic           fpu_op0, busy0;
  logic [1:0]     cur_id0;

  logic [N-1:0]   req_valid1, req_op1, req_ready1, resp_valid1;
  logic [N*W-1:0] req_a1, req_b1;
  logic [W-1:0]   resp_value1, fpu_a1, fpu_b1, fpu_value1;
  logic           fpu_op1, busy1;
  logic [1:0]     cur_id1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub units: a^b is valid FPU_LATENCY cycles after the scheduler registers operands.
  always @(posedge clk) stub0_q <= fpu_a0 ^ fpu_b0;
  assign fpu_value0 = stub0_q;
  assign fpu_value1 = fpu_a1 ^ fpu_b1;

  fpu_scheduler #(.NUM_REQ(N), .WIDTH(W), .FPU_LATENCY(2)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid0),
    .req_a      (req_a0),
    .req_b      (req_b0),
    .req_op     (req_op0),
    .req_ready  (req_ready0),
    .resp_valid (resp_valid0),
    .resp_value (resp_value0),
    .fpu_a      (fpu_a0),
    .fpu_b      (fpu_b0),
    .fpu_op     (fpu_op0),
    .fpu_value  (fpu_value0),
    .busy       (busy0),
    .cur_id     (cur_id0)
  );

  fpu_scheduler #(.NUM_REQ(N), .WIDTH(W), .FPU_LATENCY(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid1),
    .req_a      (req_a1),
    .req_b      (req_b1),
    .req_op     (req_op1),
    .req_ready  (req_ready1),
    .resp_valid (resp_valid1),
    .resp_value (resp_value1),
    .fpu_a      (fpu_a1),
    .fpu_b      (fpu_b1),
    .fpu_op     (fpu_op1),
    .fpu_value  (fpu_value1),
    .busy       (busy1),
    .cur_id     (cur_id1)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(int id, logic [31:0] a, logic [31:0] b, logic op);
    req_a0[id*W +: W] = a;
    req_b0[id*W +: W] = b;
    req_op0[id]       = op;
    opa0[id]          = a;
    opb0[id]          = b;
  endtask

  task automatic drive1(int id, logic [31:0] a, logic [31:0] b, logic op);
    req_a1[id*W +: W] = a;
    req_b1[id*W +: W] = b;
    req_op1[id]       = op;
    opa1[id]          = a;
    opb1[id]          = b;
  endtask

  // Called at the negedge of the cycle whose closing edge accepts requester id.
  task automatic grant0(string tag, int id, logic [31:0] val);
    exp_t e;
    check(tag, 32'(req_ready0), 32'(1) << id);
    e.id  = id;
    e.val = val;
    e.cyc = cyc + 3;
    sb0.push_back(e);
  endtask

  task automatic grant1(string tag, int id, logic [31:0] val);
    exp_t e;
    check(tag, 32'(req_ready1), 32'(1) << id);
    e.id  = id;
    e.val = val;
    e.cyc = cyc + 2;
    sb1.push_back(e);
  endtask

  task automatic drain0(int max_cyc);
    for (int i = 0; i < max_cyc && sb0.size() != 0; i++) @(negedge clk);
    check("drain0", 32'(sb0.size()), 32'd0);
  endtask

  task automatic drain1(int max_cyc);
    for (int i = 0; i < max_cyc && sb1.size() != 0; i++) @(negedge clk);
    check("drain1", 32'(sb1.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && |resp_valid0) begin
      if (sb0.size() == 0) begin
        check("resp0_unexpected", 32'(resp_valid0), 32'd0);
      end else begin
        e0 = sb0.pop_front();
        check("resp0_id", 32'(resp_valid0), 32'(1) << e0.id);
        check("resp0_value", resp_value0, e0.val);
        check("resp0_cycle", 32'(cyc), 32'(e0.cyc));
      end
    end
    if (!rst && |resp_valid1) begin
      if (sb1.size() == 0) begin
        check("resp1_unexpected", 32'(resp_valid1), 32'd0);
      end else begin
        e1 = sb1.pop_front();
        check("resp1_id", 32'(resp_valid1), 32'(1) << e1.id);
        check("resp1_value", resp_value1, e1.val);
        check("resp1_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid0 = '0;
    req_a0     = '0;
    req_b0     = '0;
    req_op0    = '0;
    req_valid1 = '0;
    req_a1     = '0;
    req_b1     = '0;
    req_op1    = '0;

    // Reset state, with a request already pending to show ready stays low.
    drive0(0, 32'h1111_0000, 32'h0000_2222, 1'b1);
    req_valid0 = 4'b0001;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready0), 32'd0);
    check("rst_resp_valid", 32'(resp_valid0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_cur_id", 32'(cur_id0), 32'd0);
    check("rst_fpu_a", fpu_a0, 32'd0);
    check("rst_fpu_op", 32'(fpu_op0), 32'd0);
    check("rst_resp_value", resp_value0, 32'd0);
    req_valid0 = '0;
    step();
    rst = 1'b0;

    // Single request.
    drive0(0, 32'h447a_0000, 32'hc120_0000, 1'b1);
    req_valid0 = 4'b0001;
    @(negedge clk);
    grant0("t1_grant", 0, 32'h855a_0000);
    step();
    req_valid0 = '0;
    @(negedge clk);
    check("t1_fpu_op", 32'(fpu_op0), 32'd1);
    check("t1_fpu_a", fpu_a0, 32'h447a_0000);
    check("t1_fpu_b", fpu_b0, 32'hc120_0000);
    check("t1_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    check("t1_fpu_op_hold2", 32'(fpu_op0), 32'd1);
    check("t1_fpu_a_hold2", fpu_a0, 32'h447a_0000);
    drain0(10);

    // All four requesting continuously from reset: 0,1,2,3,0 four cycles apart.
    step();
    rst = 1'b1;
    for (int i = 0; i < N; i++)
      drive0(i, 32'h3f80_0000 + 32'(i) * 32'h0011_0000, 32'h0000_5a5a << i, i[0]);
    req_valid0 = 4'b1111;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      grant0($sformatf("t2_grant%0d", k), k % N, opa0[k % N] ^ opb0[k % N]);
      if (k == 4) begin
        step();
        req_valid0 = '0;
      end else begin
        @(negedge clk);
        check($sformatf("t2_fpu_op%0d", k), 32'(fpu_op0), 32'(k % 2));
        @(negedge clk);
        check($sformatf("t2_ready_gap%0d", k), 32'(req_ready0), 32'd0);
        repeat (2) @(negedge clk);
      end
    end
    drain0(30);

    // Wrap-around: serve 2 to move the pointer to 3, then 3 goes before 1.
    step();
    drive0(2, 32'h4000_0000, 32'h0123_4567, 1'b0);
    req_valid0 = 4'b0100;
    @(negedge clk);
    grant0("t3_grant2", 2, opa0[2] ^ opb0[2]);
    step();
    drive0(1, 32'hdead_beef, 32'h0f0f_0f0f, 1'b1);
    drive0(3, 32'hcafe_f00d, 32'hffff_0000, 1'b0);
    req_valid0 = 4'b1010;
    repeat (4) @(negedge clk);
    grant0("t3_grant3", 3, opa0[3] ^ opb0[3]);
    step();
    req_valid0 = 4'b0010;
    @(negedge clk);
    check("t3_cur_id", 32'(cur_id0), 32'd3);
    repeat (3) @(negedge clk);
    grant0("t3_grant1", 1, opa0[1] ^ opb0[1]);
    step();
    req_valid0 = '0;
    drain0(10);

    // Withdrawn request: requester 2 pulses valid for one cycle while busy.
    step();
    drive0(0, 32'h1357_9bdf, 32'h2468_ace0, 1'b0);
    req_valid0 = 4'b0001;
    @(negedge clk);
    grant0("t4_grant0", 0, opa0[0] ^ opb0[0]);
    step();
    drive0(2, 32'h7777_7777, 32'h1111_1111, 1'b1);
    req_valid0 = 4'b0100;
    @(negedge clk);
    check("t4_ready_busy", 32'(req_ready0), 32'd0);
    step();
    req_valid0 = '0;
    drain0(10);
    repeat (3) @(negedge clk);
    check("t4_idle_busy", 32'(busy0), 32'd0);
    check("t4_cur_id", 32'(cur_id0), 32'd0);

    // Reset mid-operation: outputs clear at once, no response, then normal service.
    step();
    drive0(1, 32'habcd_0123, 32'h5555_aaaa, 1'b1);
    req_valid0 = 4'b0010;
    @(negedge clk);
    check("t5_ready1", 32'(req_ready0), 32'b0010);
    step();
    req_valid0 = '0;
    @(negedge clk);
    check("t5_busy_hold", 32'(busy0), 32'd1);
    #1;
    rst = 1'b1;
    req_valid0 = 4'b0100;
    #1;
    check("t5_rst_fpu_a", fpu_a0, 32'd0);
    check("t5_rst_fpu_b", fpu_b0, 32'd0);
    check("t5_rst_fpu_op", 32'(fpu_op0), 32'd0);
    check("t5_rst_busy", 32'(busy0), 32'd0);
    check("t5_rst_cur_id", 32'(cur_id0), 32'd0);
    check("t5_rst_resp_value", resp_value0, 32'd0);
    check("t5_rst_resp_valid", 32'(resp_valid0), 32'd0);
    check("t5_rst_req_ready", 32'(req_ready0), 32'd0);
    req_valid0 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_post_rst_busy", 32'(busy0), 32'd0);
    step();
    drive0(3, 32'h4049_0fdb, 32'h3f80_0000, 1'b0);
    req_valid0 = 4'b1000;
    @(negedge clk);
    grant0("t5_grant3", 3, opa0[3] ^ opb0[3]);
    step();
    req_valid0 = '0;
    drain0(10);

    // Minimum latency instance: response two cycles after accept, issue every three.
    step();
    drive1(0, 32'h447a_0000, 32'hc120_0000, 1'b1);
    drive1(1, 32'h0bad_f00d, 32'h1234_5678, 1'b0);
    req_valid1 = 4'b0011;
    @(negedge clk);
    grant1("t6_grant0", 0, 32'h855a_0000);
    step();
    req_valid1 = 4'b0010;
    @(negedge clk);
    check("t6_fpu_op", 32'(fpu_op1), 32'd1);
    repeat (2) @(negedge clk);
    grant1("t6_grant1", 1, opa1[1] ^ opb1[1]);
    step();
    req_valid1 = '0;
    drain1(10);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
